reaction_timer_core: RTL
========================

# reaction_timer_core

Parametrised reaction-time measurement core for the reaction-timer game. Built-in pieces:
- LFSR-randomised start delay.
- Stimulus output.
- Millisecond-style tick prescaler.
- Saturating score counter.
- False-start and timeout detection.
- Last/best score registers.

It sits between the debounced button inputs and the seven-segment display driver.

## Interface
Parameters:
- `LFSR_W`, 8 — LFSR width.
- `LFSR_TAPS`, 8'h8E — Galois feedback mask, `LFSR_W` bits.
- `CNT_W`, 13 — delay counter width.
- `BASE_DELAY`, 1000 — fixed delay component, in ticks.
- `RAND_SHIFT`, 4 — left shift applied to the LFSR value.
- `SCORE_W`, 16 — score width.
- `TICK_DIV`, 50000 — clocks per tick; must be ≥ 2.

Ports:
- `clk`  in  1  — sole clock, rising edge.
- `reset`  in  1  — synchronous, active-low; 0 at a rising edge resets the whole block.
- `start`  in  1  — level, sampled each clock; requests a new trial.
- `stop`  in  1  — level, sampled each clock; player response.
- `clear_best`  in  1  — reloads the best register with its reset value.
- `led`  out  1  — stimulus lit.
- `busy`  out  1  — high in WAIT or LIT.
- `score_valid`  out  1  — one-cycle pulse when a new score is committed.
- `false_start`  out  1  — sticky until the next accepted `start`.
- `timeout`  out  1  — sticky until the next accepted `start`.
- `score`  out  `SCORE_W`  — last committed score.
- `best`  out  `SCORE_W`  — lowest committed score.

## Operation
State machine states: IDLE, WAIT, LIT, DONE, FAULT.

Transitions:
- IDLE / DONE / FAULT, `start`=1 → WAIT.
  - Load the delay counter with `BASE_DELAY + (lfsr << RAND_SHIFT)`, truncated to `CNT_W` bits (modulo 2^CNT_W).
  - Clear `false_start` and `timeout`.
- WAIT, `stop`=1 → FAULT.
  - Set `false_start`=1.
  - `score` and `best` are unchanged; no `score_valid` pulse.
- WAIT, tick and counter==0 → LIT; clear the score counter.
- WAIT, tick and counter≠0 → counter−1.
- LIT, tick → score counter +1 (saturating at MAX).
  - MAX is all-ones in binary mode, or all-9 digits in BCD mode.
- LIT, counter reaches MAX → DONE.
  - Set `timeout`=1 and commit MAX as the score.
- LIT, `stop`=1 → DONE; commit the score.

Commit rules:
- On commit, `score` takes the counter value and `score_valid` pulses.
- If `score < best` (strict, unsigned), `best` takes the score in the same edge.

LFSR:
- Galois type, advances every clock regardless of state; the free-running clock provides the entropy.
- Reset seed is all-ones, and the all-zero state is unreachable.

Prescaler:
- Counts 0..`TICK_DIV`−1; tick is asserted when the count equals `TICK_DIV`−1.
- Cleared on entry to WAIT and on entry to LIT, so the first tick in each state falls exactly `TICK_DIV` cycles after entry.

Simultaneous events:
- `start` and `stop` together in IDLE/DONE/FAULT: `start` wins.
- `start` in WAIT/LIT: ignored.
- `stop` and tick together in LIT: the increment is applied first, and the incremented value is committed.
- `stop` together with the saturating tick: treated as a timeout.
- `stop` and the final tick together in WAIT: false start.
- `clear_best` together with a commit: the clear wins.

Outputs:
- `led` = (state==LIT).
- `busy` = WAIT|LIT.

Reset values:
- State: IDLE.
- `led`, `busy`, `score_valid`, `false_start`, `timeout`: 0.
- `score`: 0.
- `best`: MAX.
- LFSR: all-ones.
- Delay counter and prescaler: 0.

## Timing
- All outputs are registered.
- `start` sampled at edge N → `busy`=1 after edge N.
- `stop` sampled at edge N in LIT:
  - `led`=0, `score`, `best` and `score_valid` all update at edge N.
  - `score_valid` is low again after edge N+1.
- WAIT → LIT: exactly (D+1)·`TICK_DIV` cycles after entering WAIT, where D is the loaded delay.
- Reset mid-operation: the next edge returns to IDLE and clears everything, including `best`.

## Configuration
- `RT_BCD_EN` defined:
  - The score counter is packed BCD (`SCORE_W`/4 digits, each wrapping 9→0 with carry).
  - MAX and the `best` reset value are all-9s (16'h9999 at default width).
  - `SCORE_W` must be a multiple of 4.
  - The comparison stays unsigned, since BCD ordering is preserved.
- Undefined:
  - Plain binary counter; MAX and the `best` reset value are all-ones.

## Test plan
All scenarios use `TICK_DIV`=4, `BASE_DELAY`=2, `RAND_SHIFT`=0, and `LFSR_W`=`CNT_W`=8 (so that scenario 6 can wrap), except where a scenario states otherwise.
1. Reset, then hold `reset`=0 for 3 clocks → `led`=0, `score`=0, `best`=FFFF (binary) or 9999 (`RT_BCD_EN`), state IDLE.
2. Pulse `start`, wait for `led`, then `stop` after 7 ticks → one `score_valid` pulse, `score`=7, `best`=7. A second trial scoring 9 → `score`=9, `best` stays 7.
3. `stop` during WAIT → `false_start`=1, `led` never rises, `score` and `best` unchanged, no pulse. Next `start` clears `false_start`.
4. Bench with `SCORE_W`=4, no `stop` → `timeout`=1 with `score`=F; with `RT_BCD_EN` (still `SCORE_W`=4) → `score`=9.
5. `RT_BCD_EN`, `stop` after 12 ticks → `score`=16'h0012.
6. Force LFSR value FF with `BASE_DELAY`=2 → delay wraps to 1, so LIT begins 8 cycles after WAIT entry. Assert `reset`=0 while in LIT → IDLE on the next edge, `best` back to MAX.

Source files
------------

// File: rtl/reaction_timer_core.sv
// Reaction-timer core: LFSR start delay, tick prescaler, saturating score, last/best registers.
// Define RT_BCD_EN to count the score in packed BCD instead of binary.
module reaction_timer_core #(
    parameter int unsigned        LFSR_W     = 8,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS  = 8'h8E,
    parameter int unsigned        CNT_W      = 13,
    parameter int unsigned        BASE_DELAY = 1000,
    parameter int unsigned        RAND_SHIFT = 4,
    parameter int unsigned        SCORE_W    = 16,
    parameter int unsigned        TICK_DIV   = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               clear_best,
    output logic               led,
    output logic               busy,
    output logic               score_valid,
    output logic               false_start,
    output logic               timeout,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best
);

    localparam int unsigned       PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
`ifdef RT_BCD_EN
    localparam logic [SCORE_W-1:0] SCORE_MAX = {(SCORE_W/4){4'h9}};
`else
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_LIT   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [SCORE_W-1:0] acc_q, acc_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic               sv_q, sv_d;
    logic               fs_q, fs_d;
    logic               to_q, to_d;
    logic               tick_c;
    logic               commit;
    logic [SCORE_W-1:0] commit_val;
    logic [SCORE_W-1:0] acc_inc;

    // One increment of the score counter, binary or per-digit BCD with carry.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        logic               carry;
        r     = v;
        carry = 1'b1;
`ifdef RT_BCD_EN
        for (int unsigned i = 0; i < SCORE_W / 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
`else
        r = r + SCORE_W'(carry);
`endif
        return r;
    endfunction

    assign tick_c = (pre_q == PRE_LAST);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        score_d    = score_q;
        best_d     = best_q;
        sv_d       = 1'b0;
        fs_d       = fs_q;
        to_d       = to_q;
        commit     = 1'b0;
        commit_val = acc_q;
        pre_d      = tick_c ? '0 : pre_q + PRE_W'(1);
        acc_inc    = (acc_q == SCORE_MAX) ? acc_q : score_inc(acc_q);
        lfsr_d     = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);

        case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(BASE_DELAY) + (CNT_W'(lfsr_q) << RAND_SHIFT);
                    pre_d   = '0;
                    fs_d    = 1'b0;
                    to_d    = 1'b0;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_FAULT;
                    fs_d    = 1'b1;
                end else if (tick_c) begin
                    if (cnt_q == '0) begin
                        state_d = S_LIT;
                        acc_d   = '0;
                        pre_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_LIT: begin
                if (tick_c) begin
                    acc_d = acc_inc;
                end
                // Saturation outranks a simultaneous stop.
                if (tick_c && (acc_inc == SCORE_MAX)) begin
                    state_d    = S_DONE;
                    to_d       = 1'b1;
                    commit     = 1'b1;
                    commit_val = SCORE_MAX;
                end else if (stop) begin
                    state_d    = S_DONE;
                    commit     = 1'b1;
                    commit_val = tick_c ? acc_inc : acc_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            score_d = commit_val;
            sv_d    = 1'b1;
        end
        if (clear_best) begin
            best_d = SCORE_MAX;
        end else if (commit && (commit_val < best_q)) begin
            best_d = commit_val;
        end

        led_d  = (state_d == S_LIT);
        busy_d = (state_d == S_WAIT) || (state_d == S_LIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= '1;
            cnt_q   <= '0;
            pre_q   <= '0;
            acc_q   <= '0;
            score_q <= '0;
            best_q  <= SCORE_MAX;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            sv_q    <= 1'b0;
            fs_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            acc_q   <= acc_d;
            score_q <= score_d;
            best_q  <= best_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            sv_q    <= sv_d;
            fs_q    <= fs_d;
            to_q    <= to_d;
        end
    end

    assign led         = led_q;
    assign busy        = busy_q;
    assign score_valid = sv_q;
    assign false_start = fs_q;
    assign timeout     = to_q;
    assign score       = score_q;
    assign best        = best_q;

endmodule
